mp_cache_ctrl: RTL
==================

Name: mp_cache_ctrl

Overview:
- Parametrised successor to the two-processor shared data cache.
- Serves NUM_PORTS requesters through a round-robin arbiter with valid/ready handshakes.
- Direct-mapped, with real valid bits, miss detection, multi-word line refill from a backing-memory port, and write-through stores.
- Sits between the processor cores and main memory; exactly one request is in flight at a time.

Parameters:
- NUM_PORTS, 2: requester count (>=2).
- ADDR_W, 12: word-address width.
- DATA_W, 8: data word width.
- NUM_LINES, 16: cache lines; power of 2.
- WORDS_PER_LINE, 2: words per line; power of 2, >=2.
- Derived, not overridable:
  - PORT_W = clog2(NUM_PORTS).
  - IDX_W = clog2(NUM_LINES).
  - OFF_W = clog2(WORDS_PER_LINE).
  - TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NUM_PORTS  per-port request present.
- req_ready  out  NUM_PORTS  per-port accept; at most one bit high.
- req_we  in  NUM_PORTS  per-port 1=store, 0=load.
- req_addr  in  NUM_PORTS*ADDR_W  per-port word address; port p occupies slice [p*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  per-port store data, sliced the same way.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_port  out  PORT_W  id of the port being answered.
- rsp_we  out  1  echo of the request type.
- rsp_hit  out  1  1 if the lookup hit.
- rsp_rdata  out  DATA_W  load data (store: the written data).
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing-memory write.
- mem_addr  out  ADDR_W  backing-memory word address.
- mem_wdata  out  DATA_W  backing-memory write data.
- mem_ack  in  1  backing-memory completion, one cycle.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM to IDLE; arbiter pointer to 0.
  - All line valid bits cleared; tag and data arrays not reset.
  - All outputs 0.
  - Reset mid-refill or mid-write aborts the operation: mem_req drops immediately and no response is produced.
- Address split: tag = addr[ADDR_W-1 -: TAG_W]; index = addr[OFF_W +: IDX_W]; offset = addr[OFF_W-1:0].
- Arbitration, evaluated combinationally in IDLE only:
  - Grant the first valid port at or after the pointer, wrapping.
  - req_ready is high for that port only.
  - On accept, the request is registered and the pointer becomes granted+1 mod NUM_PORTS.
  - Outside IDLE, req_ready is all-zero; requesters hold their request stable until ready.
- FSM states: IDLE, LOOKUP, REFILL, WRITE, RESP.
  - IDLE -> LOOKUP on accept.
  - LOOKUP: hit = valid[idx] && tag match.
    - Load hit -> RESP.
    - Load miss -> REFILL.
    - Store (hit or miss) -> WRITE; on hit the line word is updated in this cycle.
  - REFILL:
    - Reads words 0..WORDS_PER_LINE-1 of the line, base = {tag, idx, OFF_W'b0}.
    - Word counter advances on each mem_ack, and mem_rdata is written to the line.
    - mem_req stays high until the last ack, then drops.
    - After the last ack: set valid[idx], write tag, -> RESP with the requested word.
  - WRITE: mem_req=1, mem_we=1, address and data of the request; hold until mem_ack, -> RESP. Store miss does not allocate.
  - RESP: rsp_valid=1 for exactly one cycle with the registered port/we/hit/data -> IDLE.
- mem_ack outside REFILL/WRITE is ignored. mem_ack in the same cycle as mem_req rising is legal.
- Latency, counted from the accept edge:
  - Load hit: rsp_valid is high in the 2nd cycle after accept.
  - Load miss: 2 + refill cycles.
  - Store: 2 + memory-write cycles.
- Throughput: a new accept is possible in the cycle after RESP, so the minimum issue gap is 3 cycles.
- Response has no backpressure.

Decomposition:
- Package cache_pkg holds:
  - the state enum;
  - a response struct (port, we, hit, data);
  - a clog2 helper;
  - the address-split helper functions.
- One natural sub-module, rr_arbiter (NUM_PORTS): req vector, advance strobe -> one-hot grant and encoded grant id.

Test Plan:
1. Cold load: after reset, port0 loads addr 0x010 -> miss. Two mem reads at 0x010 and 0x011 with mem_rdata 0xA5 and 0x5A -> rsp port0, hit=0, rdata=0xA5.
2. Hit: port1 then loads 0x011 -> no mem_req; rsp_valid exactly 2 cycles after accept, hit=1, rdata=0x5A.
3. Contention: ports 0 and 1 both valid continuously -> accepts alternate 0,1,0,1; neither port starves.
4. Store:
   - Store 0x3C to 0x010 (hit) -> one mem write (0x010, 0x3C); a following load of 0x010 returns 0x3C with hit=1.
   - Store to uncached 0x200 -> mem write issued, a following load of 0x200 misses.
5. Conflict: load 0x010 then 0x210 (same index, different tag) -> second load misses and refills; a reload of 0x010 misses again.
6. Reset mid-refill: rst_n low during the 2nd refill word -> mem_req falls asynchronously and no rsp_valid appears. After release, a load of 0x010 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and address helpers for the multi-port cache controller
package cache_pkg;
  localparam int RSP_PORT_MAX = 8;
  localparam int RSP_DATA_MAX = 64;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;
  typedef struct packed {
    logic [RSP_PORT_MAX-1:0] port;
    logic                    we;
    logic                    hit;
    logic [RSP_DATA_MAX-1:0] data;
  } rsp_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int off_w, input int idx_w);
    return a >> (off_w + idx_w);
  endfunction
  function automatic logic [63:0] addr_idx(input logic [63:0] a, input int off_w, input int idx_w);
    return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction
  function automatic logic [63:0] addr_off(input logic [63:0] a, input int off_w);
    return a & ((64'd1 << off_w) - 64'd1);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from a rotating pointer
module rr_arbiter
  import cache_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int PORT_W    = clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 adv,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]    gnt_id
);
  logic [PORT_W-1:0]    ptr;
  logic [NUM_PORTS-1:0] rot;
  logic                 found;
  int                   sel;
  always_comb begin
    rot   = NUM_PORTS'({req, req} >> ptr);
    found = 1'b0;
    sel   = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (rot[i]) begin
        found = 1'b1;
        sel   = i;
      end
    gnt_id = PORT_W'((int'(ptr) + sel) % NUM_PORTS);
    gnt    = found ? NUM_PORTS'(1) << gnt_id : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (adv) ptr <= PORT_W'((int'(gnt_id) + 1) % NUM_PORTS);
endmodule

// File: rtl/mp_cache_ctrl.sv
// mp_cache_ctrl: round-robin multi-port direct-mapped write-through cache controller
module mp_cache_ctrl
  import cache_pkg::*;
#(
  parameter  int NUM_PORTS      = 2,
  parameter  int ADDR_W         = 12,
  parameter  int DATA_W         = 8,
  parameter  int NUM_LINES      = 16,
  parameter  int WORDS_PER_LINE = 2,
  localparam int PORT_W         = clog2(NUM_PORTS),
  localparam int IDX_W          = clog2(NUM_LINES),
  localparam int OFF_W          = clog2(WORDS_PER_LINE),
  localparam int TAG_W          = ADDR_W - IDX_W - OFF_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic                        rsp_valid,
  output logic [PORT_W-1:0]           rsp_port,
  output logic                        rsp_we,
  output logic                        rsp_hit,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata
);
  state_t                 state, state_n;
  logic [NUM_PORTS-1:0]   gnt;
  logic [PORT_W-1:0]      gnt_id;
  logic                   accept, hit, last;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [OFF_W-1:0]       cnt;
  rsp_t                   rsp_q;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]      data_mem [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]       tag;
  logic [IDX_W-1:0]       idx;
  logic [OFF_W-1:0]       off;

  assign tag    = TAG_W'(addr_tag(64'(r_addr), OFF_W, IDX_W));
  assign idx    = IDX_W'(addr_idx(64'(r_addr), OFF_W, IDX_W));
  assign off    = OFF_W'(addr_off(64'(r_addr), OFF_W));
  assign hit    = valid[idx] && tag_mem[idx] == tag;
  assign last   = cnt == OFF_W'(WORDS_PER_LINE - 1);
  assign accept = |gnt;

  // gating with rst_n keeps req_ready low while reset is held
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid & {NUM_PORTS{state == IDLE && rst_n}}),
    .adv    (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );
  assign req_ready = gnt;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? LOOKUP : IDLE;
      LOOKUP:  state_n = rsp_q.we ? WRITE : hit ? RESP : REFILL;
      REFILL:  state_n = mem_ack && last ? RESP : REFILL;
      WRITE:   state_n = mem_ack ? RESP : WRITE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_q   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      cnt     <= '0;
      valid   <= '0;
    end else begin
      if (accept) begin
        rsp_q.port <= RSP_PORT_MAX'(gnt_id);
        rsp_q.we   <= req_we[gnt_id];
        r_addr     <= req_addr[gnt_id*ADDR_W +: ADDR_W];
        r_wdata    <= req_wdata[gnt_id*DATA_W +: DATA_W];
      end
      if (state == LOOKUP) begin
        rsp_q.hit  <= hit;
        rsp_q.data <= RSP_DATA_MAX'(rsp_q.we ? r_wdata : data_mem[{idx, off}]);
        cnt        <= '0;
      end
      if (state == REFILL && mem_ack) begin
        cnt <= cnt + 1'b1;
        if (cnt == off) rsp_q.data <= RSP_DATA_MAX'(mem_rdata);
        if (last) valid[idx] <= 1'b1;
      end
    end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && rsp_q.we && hit) data_mem[{idx, off}] <= r_wdata;
    if (state == REFILL && mem_ack) begin
      data_mem[{idx, cnt}] <= mem_rdata;
      if (last) tag_mem[idx] <= tag;
    end
  end

  assign mem_req   = state == REFILL || state == WRITE;
  assign mem_we    = state == WRITE;
  assign mem_addr  = state == REFILL ? {tag, idx, cnt} : state == WRITE ? r_addr : '0;
  assign mem_wdata = mem_we ? r_wdata : '0;
  assign rsp_valid = state == RESP;
  assign rsp_port  = PORT_W'(rsp_q.port);
  assign rsp_we    = rsp_q.we;
  assign rsp_hit   = rsp_q.hit;
  assign rsp_rdata = DATA_W'(rsp_q.data);
endmodule
